// File: rtl/uart_frame_rx_if.sv
// Bundles the serial input line with the received-byte status outputs of uart_frame_rx.
// The receiver connects through the slave modport; the line driver uses master.
interface uart_frame_rx_if;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_int;
    logic       rx_done;
    logic       frame_err;

    modport master (output uart_rx, input rx_data, rx_int, rx_done, frame_err);
    modport slave  (input uart_rx, output rx_data, rx_int, rx_done, frame_err);
endinterface

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver: synchronizes the line, finds the start edge and samples each bit at its midpoint.
// A byte is published only when its stop bit is high; a low stop bit sets frame_err instead.
module uart_frame_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_frame_rx_if.slave  bus
);
    localparam int BPS_CNT  = CLK_HZ / BAUD;
    localparam int HALF_CNT = BPS_CNT / 2;
    localparam int CW       = $clog2(BPS_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_CNT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          sync1, sync2, hist;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    rx_data_q;
    logic          rx_int_q, rx_done_q, frame_err_q;
    logic          fall;

    // History flops reset high so a line already low at reset release reads as a falling edge.
    assign fall = hist & ~sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= bus.uart_rx;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data_q   <= '0;
            rx_int_q    <= 1'b0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            rx_int_q  <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync2 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {sync2, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (sync2) begin
                            rx_data_q   <= shreg;
                            rx_done_q   <= 1'b1;
                            frame_err_q <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_int    = rx_int_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx at 16 clocks per bit: valid, back-to-back,
// framing error, glitch, mid-frame reset and line-break cases.
module tb_uart_frame_rx;
    localparam int BPS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    uart_frame_rx_if bus();

    uart_frame_rx #(.CLK_HZ(160), .BAUD(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output monitor: counts rx_done pulses/high cycles, frame_err rises, rx_int run lengths.
    int         done_pulses = 0;
    int         done_cycles = 0;
    int         err_rises = 0;
    int         int_run = 0;
    int         int_last = 0;
    logic       done_d = 1'b0;
    logic       err_d = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (bus.rx_done) begin
            done_cycles++;
            if (!done_d) begin
                done_pulses++;
                got_q.push_back(bus.rx_data);
            end
        end
        if (bus.frame_err && !err_d) err_rises++;
        if (bus.rx_int) int_run++;
        else if (int_run != 0) begin
            int_last = int_run;
            int_run  = 0;
        end
        done_d = bus.rx_done;
        err_d  = bus.frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic line_bit(input logic b);
        bus.uart_rx = b;
        repeat (BPS) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        line_bit(stop);
        bus.uart_rx = 1'b1;
    endtask

    int p0, c0, e0;

    initial begin
        bus.uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'h0, bus.rx_data}, 32'h00);
        chk("rst_int",  {31'h0, bus.rx_int}, 0);
        chk("rst_done", {31'h0, bus.rx_done}, 0);
        chk("rst_err",  {31'h0, bus.frame_err}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // single valid frame
        send(8'h55, 1'b1);
        repeat (6) @(negedge clk);
        chk("f55_pulses", done_pulses, 1);
        chk("f55_width", done_cycles, 1);
        chk("f55_data", {24'h0, bus.rx_data}, 32'h55);
        chk("f55_err", {31'h0, bus.frame_err}, 0);
        chk("f55_int_len", (int_last >= 151 && int_last <= 153), 1);
        chk("f55_int_low", {31'h0, bus.rx_int}, 0);

        // back-to-back frames, no idle gap
        got_q.delete();
        send(8'hA3, 1'b1);
        send(8'h0F, 1'b1);
        repeat (6) @(negedge clk);
        chk("b2b_pulses", done_pulses, 3);
        chk("b2b_width", done_cycles, 3);
        chk("b2b_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("b2b_first", {24'h0, got_q[0]}, 32'hA3);
            chk("b2b_second", {24'h0, got_q[1]}, 32'h0F);
        end

        // stop bit low -> framing error, data held
        send(8'hFF, 1'b0);
        repeat (2 * BPS) @(negedge clk);
        chk("ferr_flag", {31'h0, bus.frame_err}, 1);
        chk("ferr_rises", err_rises, 1);
        chk("ferr_data", {24'h0, bus.rx_data}, 32'h0F);
        chk("ferr_nodone", done_pulses, 3);
        send(8'h12, 1'b1);
        repeat (6) @(negedge clk);
        chk("f12_data", {24'h0, bus.rx_data}, 32'h12);
        chk("f12_err", {31'h0, bus.frame_err}, 0);
        chk("f12_pulses", done_pulses, 4);

        // 4-clk glitch from idle
        bus.uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("gl_int_len", (int_last >= 7 && int_last <= 9), 1);
        chk("gl_nodone", done_pulses, 4);
        chk("gl_data", {24'h0, bus.rx_data}, 32'h12);
        chk("gl_err", {31'h0, bus.frame_err}, 0);
        chk("gl_int_low", {31'h0, bus.rx_int}, 0);

        // reset during bit 4 of 8'hC6
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(1'(8'hC6 >> i));
        bus.uart_rx = 1'(8'hC6 >> 4);
        repeat (BPS / 2) @(negedge clk);
        p0 = done_pulses;
        rst_n = 1'b0;
        #1;
        chk("mrst_data", {24'h0, bus.rx_data}, 32'h00);
        chk("mrst_int",  {31'h0, bus.rx_int}, 0);
        chk("mrst_done", {31'h0, bus.rx_done}, 0);
        chk("mrst_err",  {31'h0, bus.frame_err}, 0);
        bus.uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mrst_nodone", done_pulses, p0);
        send(8'h3C, 1'b1);
        repeat (6) @(negedge clk);
        chk("f3c_data", {24'h0, bus.rx_data}, 32'h3C);
        chk("f3c_pulses", done_pulses, p0 + 1);

        // line break: 30 bit times low
        c0 = done_pulses;
        e0 = err_rises;
        bus.uart_rx = 1'b0;
        repeat (30 * BPS) @(negedge clk);
        chk("brk_err", {31'h0, bus.frame_err}, 1);
        chk("brk_rises", err_rises, e0 + 1);
        chk("brk_nodone", done_pulses, c0);
        chk("brk_int_low", {31'h0, bus.rx_int}, 0);
        chk("brk_data", {24'h0, bus.rx_data}, 32'h3C);
        bus.uart_rx = 1'b1;
        repeat (2 * BPS) @(negedge clk);
        send(8'h81, 1'b1);
        repeat (6) @(negedge clk);
        chk("f81_data", {24'h0, bus.rx_data}, 32'h81);
        chk("f81_err", {31'h0, bus.frame_err}, 0);
        chk("f81_rises", err_rises, e0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
